// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle unsigned shift-add multiplier with req/ready/exception handshake
// Ports: clk, rstn (async active-low); req with Multiplicand/Multiplier operands sampled in IDLE;
//   P_hi/P_lo 2N-bit product words; ready one-cycle completion pulse; exception product >= 2**N;
//   busy high in RUN; Num_cycles edges spent on the last/current op (accept edge counts as 1).
// Build option SEQ_MUL_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req,
  input  logic [N-1:0] Multiplicand,
  input  logic [N-1:0] Multiplier,
  output logic [N-1:0] P_lo,
  output logic [N-1:0] P_hi,
  output logic         ready,
  output logic         exception,
  output logic         busy,
  output logic [N-1:0] Num_cycles
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [2*N-1:0] acc, mcand, acc_nxt;
  logic [N-1:0] mr, count;
  logic zero_op, one_a, one_b, fast, last;
  always_comb begin
    zero_op = (Multiplicand == '0) || (Multiplier == '0);
    one_a = Multiplicand == N'(1);
    one_b = Multiplier == N'(1);
    fast = zero_op || one_a || one_b;
    acc_nxt = mr[0] ? acc + mcand : acc;
`ifdef SEQ_MUL_EARLY_TERM_EN
    // once the shifted multiplier is empty no further additions can occur
    last = (count == N'(N - 1)) || (mr[N-1:1] == '0);
`else
    last = count == N'(N - 1);
`endif
    state_nxt = (state == IDLE) ? ((req && !fast) ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  assign busy = state == RUN;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      P_lo <= '0;
      P_hi <= '0;
      ready <= 1'b0;
      exception <= 1'b0;
      Num_cycles <= '0;
      acc <= '0;
      mcand <= '0;
      mr <= '0;
      count <= '0;
    end else begin
      ready <= 1'b0;
      if (state == IDLE) begin
        if (req) begin
          Num_cycles <= N'(1);
          if (fast) begin
            // trivial operands finish on the accept edge
            P_lo <= zero_op ? '0 : (one_b ? Multiplicand : Multiplier);
            P_hi <= '0;
            exception <= 1'b0;
            ready <= 1'b1;
          end else begin
            acc <= '0;
            mcand <= {{N{1'b0}}, Multiplicand};
            mr <= Multiplier;
            count <= '0;
          end
        end
      end else begin
        acc <= acc_nxt;
        mcand <= mcand << 1;
        mr <= mr >> 1;
        count <= count + N'(1);
        Num_cycles <= Num_cycles + N'(1);
        if (last) begin
          {P_hi, P_lo} <= acc_nxt;
          exception <= acc_nxt[2*N-1:N] != '0;
          ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier (N=16) against A*B
module tb_seq_multiplier;
  logic clk = 1'b0, rstn = 1'b0, req = 1'b0;
  logic [15:0] mcand = '0, mplier = '0;
  logic [15:0] p_lo, p_hi, num_cycles;
  logic ready, exception, busy;
  int compared = 0, mismatched = 0;

  seq_multiplier #(.N(16)) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .Multiplicand(mcand), .Multiplier(mplier),
    .P_lo(p_lo), .P_hi(p_hi), .ready(ready), .exception(exception),
    .busy(busy), .Num_cycles(num_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [15:0] a, input logic [15:0] b);
    int m = 0;
    if (a == 0 || b == 0 || a == 1 || b == 1) return 1;
    for (int i = 0; i < 16; i++) if (b[i]) m = i;
`ifdef SEQ_MUL_EARLY_TERM_EN
    return m + 2;
`else
    return 17;
`endif
  endfunction

  // issues one op, waits for ready, checks result, latency, busy span and pulse width
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [31:0] p = {16'h0, a} * {16'h0, b};
    int lat = 0, bz = 0, ec = exp_cycles(a, b);
    @(negedge clk);
    mcand = a; mplier = b; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    while (!ready && lat < 40) begin
      if (busy) bz++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, ec - 1);
    check({tag, "_busy"}, bz, ec - 1);
    check({tag, "_prod"}, {p_hi, p_lo}, p);
    check({tag, "_exc"}, exception, p[31:16] != 0);
    check({tag, "_ncyc"}, num_cycles, ec);
    @(negedge clk);
    check({tag, "_pulse"}, ready, 0);
    check({tag, "_hold"}, {p_hi, p_lo}, p);
  endtask

  initial begin
    int lat, seen;
    repeat (2) @(negedge clk);
    check("rst_lo", p_lo, 0);
    check("rst_hi", p_hi, 0);
    check("rst_flags", {ready, exception, busy}, 0);
    check("rst_ncyc", num_cycles, 0);
    rstn = 1'b1;
    @(negedge clk);
    do_op(16'h00FF, 16'h0003, "t1");
    check("t1_lo", p_lo, 32'h02FD);
    do_op(16'hFFFF, 16'hFFFF, "t2");
    check("t2_hi", p_hi, 32'hFFFE);
    check("t2_lo", p_lo, 32'h0001);
    check("t2_exc", exception, 1);
    do_op(16'h1234, 16'h0000, "t3_b0");
    do_op(16'h0000, 16'h5678, "t3_a0");
    do_op(16'h1234, 16'h0001, "t3_b1");
    check("t3_b1_lo", p_lo, 32'h1234);
    do_op(16'h0001, 16'hBEEF, "t3_a1");
    check("t3_a1_lo", p_lo, 32'hBEEF);
    do_op(16'h0002, 16'h8000, "t3_edge");
    // back-to-back with req held high; operands changed mid-RUN must be ignored
    @(negedge clk);
    mcand = 16'd7; mplier = 16'd6; req = 1'b1;
    @(negedge clk);
    mcand = 16'd9; mplier = 16'd9;
    lat = 0;
    while (!ready && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_first", p_lo, 42);
    check("b2b_first_lat", lat, exp_cycles(7, 6) - 1);
    @(negedge clk);
    req = 1'b0;
    check("b2b_drop", ready, 0);
    check("b2b_busy", busy, 1);
    lat = 0;
    while (!ready && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_second", p_lo, 81);
    check("b2b_second_hi", p_hi, 0);
    // asynchronous reset in the middle of an op
    @(negedge clk);
    mcand = 16'h0100; mplier = 16'h0100; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_prod", {p_hi, p_lo}, 0);
    check("mid_rst_flags", {ready, exception, busy}, 0);
    check("mid_rst_ncyc", num_cycles, 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (ready) seen++; end
    check("mid_no_ready", seen, 0);
    do_op(16'h0100, 16'h0100, "t5");
    check("t5_hi", p_hi, 1);
    check("t5_exc", exception, 1);
    for (int i = 0; i < 300; i++) do_op(16'($urandom), 16'($urandom), "rnd");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
